// File: rtl/mem_bus_master.sv
// mem_bus_master: initiator for a synchronous single-port memory with a shared
// tri-state data bus. Turns CPU burst commands (start address, beats-1) into
// pipelined memory read cycles or handshaked write cycles.
module mem_bus_master #(
    parameter int WIDTH_ADDRESS_BIT = 5,
    parameter int WIDTH_REG         = 8,
    parameter int WIDTH_LEN         = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_we,
    input  logic [WIDTH_ADDRESS_BIT-1:0] cmd_addr,
    input  logic [WIDTH_LEN-1:0]         cmd_len,
    input  logic                         wdata_valid,
    output logic                         wdata_ready,
    input  logic [WIDTH_REG-1:0]         wdata,
    output logic                         rdata_valid,
    output logic [WIDTH_REG-1:0]         rdata,
    output logic                         done,
    output logic                         busy,
    output logic                         mem_rd,
    output logic                         mem_wr,
    output logic [WIDTH_ADDRESS_BIT-1:0] mem_addr,
    inout  wire  [WIDTH_REG-1:0]         mem_data
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_TAIL = 3'd2,
        S_TURN    = 3'd3,
        S_WR      = 3'd4
    } state_t;

    state_t                         r_state;
    logic [WIDTH_ADDRESS_BIT-1:0]   r_addr;       // current beat address, doubles as mem_addr
    logic [WIDTH_LEN-1:0]           r_remaining;  // beats left after the current one
    logic                           r_first;      // first RD cycle: nothing on the bus yet
    logic                           r_mem_rd;
    logic [WIDTH_REG-1:0]           r_rdata;
    logic                           r_rdata_valid;
    logic                           r_done;

    logic                           w_in_idle;
    logic                           w_in_wr;
    logic                           w_mem_wr;
    logic                           w_drive_bus;
    logic                           w_last;

    assign w_in_idle   = (r_state == S_IDLE);
    assign w_in_wr     = (r_state == S_WR);
    assign w_last      = (r_remaining == '0);
    // A write strobe exists only for a beat that is offered in WR.
    assign w_mem_wr    = w_in_wr && wdata_valid;
    // Never fight the memory: drive only while writing and not reading.
    assign w_drive_bus = w_mem_wr && !r_mem_rd;

    assign cmd_ready   = w_in_idle;
    assign busy        = !w_in_idle;
    assign wdata_ready = w_in_wr;
    assign mem_rd      = r_mem_rd;
    assign mem_wr      = w_mem_wr;
    assign mem_addr    = r_addr;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign done        = r_done;
    assign mem_data    = w_drive_bus ? wdata : {WIDTH_REG{1'bz}};

    // Burst sequencer: accepts commands, issues addresses, captures read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_first       <= 1'b0;
            r_mem_rd      <= 1'b0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_done        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_addr      <= cmd_addr;
                        r_remaining <= cmd_len;
                        r_first     <= 1'b1;
                        if (cmd_we) begin
                            r_state <= S_WR;
                        end else begin
                            r_state  <= S_RD;
                            r_mem_rd <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    // The bus carries the word addressed in the previous cycle.
                    if (!r_first) begin
                        r_rdata       <= mem_data;
                        r_rdata_valid <= 1'b1;
                    end
                    r_first <= 1'b0;
                    if (w_last) begin
                        r_state <= S_RD_TAIL;
                    end else begin
                        r_remaining <= r_remaining - 1'b1;
                        r_addr      <= r_addr + 1'b1;
                    end
                end
                S_RD_TAIL: begin
                    // Collect the final word and release the bus.
                    r_rdata       <= mem_data;
                    r_rdata_valid <= 1'b1;
                    r_done        <= 1'b1;
                    r_mem_rd      <= 1'b0;
                    r_state       <= S_TURN;
                end
                S_TURN: begin
                    // One dead cycle so the memory has stopped driving.
                    r_state <= S_IDLE;
                end
                S_WR: begin
                    if (wdata_valid) begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_remaining <= r_remaining - 1'b1;
                            r_addr      <= r_addr + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_mem_rd <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Initiator side of the synchronous single-port memory bus: sequences `rd`/`wr`/`addr` and drives or samples the shared tri-state data bus.
- Converts CPU-side burst commands (address + beat count) into memory cycles.
- Returns read data through a valid strobe; takes write data through a valid/ready handshake.
- Sits between the CPU control unit and the program/data memory.

Parameters:
- WIDTH_ADDRESS_BIT, 5, memory address width; address space 2**WIDTH_ADDRESS_BIT words.
- WIDTH_REG, 8, data word width.
- WIDTH_LEN, 3, burst length field width; beats = cmd_len+1, max 2**WIDTH_LEN.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at an edge.
- cmd_we  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  WIDTH_ADDRESS_BIT  start address.
- cmd_len  in  WIDTH_LEN  beats minus one.
- wdata_valid  in  1  write beat available.
- wdata_ready  out  1  write beat consumed when wdata_valid && wdata_ready.
- wdata  in  WIDTH_REG  write beat data.
- rdata_valid  out  1  one-cycle strobe per read beat; no backpressure.
- rdata  out  WIDTH_REG  read beat data, registered.
- done  out  1  one-cycle pulse when a burst completes.
- busy  out  1  high when state != IDLE.
- mem_rd  out  1  memory read enable.
- mem_wr  out  1  memory write enable.
- mem_addr  out  WIDTH_ADDRESS_BIT  memory address.
- mem_data  inout  WIDTH_REG  shared data bus.

Behaviour:
- Memory contract:
  - Memory registers mem[addr] into its output on a clk edge while rd && !wr.
  - It drives the bus while rd && !wr.
  - It writes the bus into mem[addr] on an edge while wr.
- States: IDLE, RD, RD_TAIL, TURN, WR.
- Reset (async, immediate): state IDLE; mem_rd=0, mem_wr=0, mem_addr=0, mem_data=Z, rdata=0, rdata_valid=0, done=0, busy=0, wdata_ready=0, cmd_ready=1. Any in-flight burst is discarded.
- cmd_ready = (state==IDLE), combinational. Commands presented while busy are not accepted and must be held by the requester.
- On acceptance, latch cur_addr=cmd_addr, remaining=cmd_len, and the direction. Next state is RD or WR.
- Address increments modulo 2**WIDTH_ADDRESS_BIT (31 -> 0 at default).
- RD, pipelined at one beat per cycle:
  - mem_rd=1 and mem_addr=cur_addr in every RD/RD_TAIL cycle.
  - Each RD cycle except the first samples mem_data (the previous address's word) into rdata; rdata_valid=1 the following cycle.
  - After issuing an address: if remaining==0 go to RD_TAIL (address held); else remaining--, cur_addr++, stay in RD.
  - RD_TAIL samples the last word, then goes to TURN.
  - mem_rd is high for beats+1 consecutive cycles.
  - First rdata_valid occurs in the 3rd cycle after the accept edge, followed by one rdata_valid per cycle thereafter.
- TURN:
  - mem_rd=0, mem_wr=0, bus Z, cmd_ready=0 for exactly one cycle, then IDLE.
  - Guarantees the memory has released the bus before any write.
- WR:
  - wdata_ready=1 in every WR cycle.
  - mem_wr = wdata_valid (combinational in WR); mem_addr=cur_addr.
  - mem_data driven with wdata only while mem_wr=1 && mem_rd=0; otherwise Z.
  - Per accepted beat: on the last beat go to IDLE, else cur_addr++ and remaining--.
  - With wdata_valid low: no write, address held, no timeout.
- done:
  - Read: pulses in the same cycle as the last rdata_valid.
  - Write: pulses in the cycle after the last write edge.
- mem_rd and mem_wr are never high together. This block never drives mem_data while mem_rd=1.
- mem_addr holds its last value in IDLE/TURN.

Test Plan:
- Preload mem[5]=8'hA5; read addr 5, len 0 -> mem_rd high 2 cycles; rdata_valid and done in cycle 3 after accept; rdata=8'hA5.
- Write addr 30, len 3, data 11,22,33,44 (wdata_valid continuous) -> writes land at 30,31,0,1 (wrap); done next cycle. Read back from 30, len 3 -> rdata 11,22,33,44 on four consecutive cycles.
- Write addr 2, len 1 with wdata_valid low for 3 cycles between beats -> mem_wr only on valid cycles; mem_addr holds 2 until beat 0 accepted; mem[3] written last.
- Preload mem[i]=i+8'h40; read addr 0, len 7 -> mem_rd high 9 cycles; 8 back-to-back rdata_valid with 8'h40..8'h47.
- Read command immediately followed by write command -> one TURN cycle with mem_rd=mem_wr=0; mem_data never X; cmd_ready low until IDLE.
- Assert rst_n=0 during read beat 3 of 8 -> mem_rd, rdata_valid, busy drop asynchronously and bus goes Z. After release, cmd_ready=1 and a new len-0 read returns correct data.
